// File: rtl/alkmdseq_pkg.sv
// rtl/alkmdseq_pkg.sv - shared types and constants for the ALK multiply/divide step sequencer
package alk_pkg;

    // Iterations per MUL/DIV operation unless the instance overrides it
    localparam int STEPS_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_DIV   = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // ALU operation select issued each step
    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

endpackage

// File: rtl/alkmdseq_if.sv
// rtl/alkmdseq_if.sv - microcode/ALU handshake bundle between the sequencer and its neighbours
//
// master : microsequencer/ALU side (drives requests, MQ LSB and ALKC flag)
// slave  : the step sequencer (drives ALU op select, strobes and status)
interface alkmdseq_if;
    logic start_mul_h;
    logic start_div_h;
    logic divz_h;
    logic abort_h;
    logic mq_lsb_h;
    logic alkc_flag_h;

    logic alpctl_mul_l;
    logic alu_add_h;
    logic alu_sub_h;
    logic q_bit_h;
    logic step_h;
    logic busy_h;
    logic stall_l;
    logic done_h;
    logic ovf_h;
    logic err_h;

    modport master (
        output start_mul_h, start_div_h, divz_h, abort_h, mq_lsb_h, alkc_flag_h,
        input  alpctl_mul_l, alu_add_h, alu_sub_h, q_bit_h, step_h,
               busy_h, stall_l, done_h, ovf_h, err_h
    );

    modport slave (
        input  start_mul_h, start_div_h, divz_h, abort_h, mq_lsb_h, alkc_flag_h,
        output alpctl_mul_l, alu_add_h, alu_sub_h, q_bit_h, step_h,
               busy_h, stall_l, done_h, ovf_h, err_h
    );
endinterface

// File: rtl/alkmdseq_cnt.sv
// rtl/alkmdseq_cnt.sv - loadable CW-bit step down-counter with zero flag
//
// clk        : clock
// rst        : asynchronous reset, active high (count -> 0)
// clr_i      : synchronous clear (abort), highest priority
// load_i     : load load_val_i
// dec_i      : decrement; holds at zero, never wraps
// load_val_i : value loaded on load_i
// cnt_o      : current count
// zero_o     : count == 0
module alkmdcnt #(
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic          dec_i,
    input  logic [CW-1:0] load_val_i,
    output logic [CW-1:0] cnt_o,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alkmdseq.sv
// rtl/alkmdseq.sv - ALK multiply/divide step sequencer feeding the ALKC carry flag
//
// qdclk_l : clock, all state updates on its rising edge
// reset_h : asynchronous reset, active high
// bus     : alkmdseq_if.slave
//   in : start_mul_h, start_div_h, divz_h, abort_h, mq_lsb_h, alkc_flag_h
//   out: alpctl_mul_l, alu_add_h, alu_sub_h, q_bit_h, step_h,
//        busy_h, stall_l, done_h, ovf_h, err_h
//
// The ALU op must react to alkc_flag_h within the same cycle (the flag
// reflects the step issued one cycle earlier), so the op select and quotient
// bit are decoded from the registered state plus the live flag/MQ LSB.
module alkmdseq
    import alk_pkg::*;
#(
    parameter int STEPS = STEPS_DEF,
    parameter int CW    = 6
) (
    input  logic        qdclk_l,
    input  logic        reset_h,
    alkmdseq_if.slave   bus
);

    state_t        state_q;
    logic          last_sub_q;   // op issued by the previous DIV step was SUB
    logic          first_q;      // current DIV cycle is the first step
    logic          ovf_q;        // DONE was reached through divide-by-zero
    logic          err_q;        // both starts seen in IDLE last cycle

    logic [CW-1:0] cnt;
    logic          cnt_zero;
    logic          cnt_load;
    logic          cnt_dec;

    logic          neg;
    logic [1:0]    alu_op;
    logic          req_mul;
    logic          req_div;
    logic          req_divz;

    // Requests are only meaningful in IDLE; both at once is an error, not a start
    assign req_mul  = (state_q == ST_IDLE) && bus.start_mul_h && !bus.start_div_h;
    assign req_div  = (state_q == ST_IDLE) && bus.start_div_h && !bus.start_mul_h && !bus.divz_h;
    assign req_divz = (state_q == ST_IDLE) && bus.start_div_h && !bus.start_mul_h &&  bus.divz_h;

    // Partial remainder sign: a borrow after SUB, or no carry after ADD, means negative
    assign neg = last_sub_q ? bus.alkc_flag_h : ~bus.alkc_flag_h;

    always_comb begin
        alu_op = ALU_PASS;
        case (state_q)
            ST_MUL:   if (bus.mq_lsb_h) alu_op = ALU_ADD;
            ST_DIV:   alu_op = (first_q || !neg) ? ALU_SUB : ALU_ADD;
            ST_FIXUP: if (neg) alu_op = ALU_ADD;
            default:  alu_op = ALU_PASS;
        endcase
    end

    assign cnt_load = !bus.abort_h && (req_mul || req_div);
    assign cnt_dec  = !bus.abort_h && ((state_q == ST_MUL) || (state_q == ST_DIV)) && !cnt_zero;

    alkmdcnt #(
        .CW (CW)
    ) u_cnt (
        .clk        (qdclk_l),
        .rst        (reset_h),
        .clr_i      (bus.abort_h),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (CW'(STEPS - 1)),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge qdclk_l or posedge reset_h) begin
        if (reset_h) begin
            state_q    <= ST_IDLE;
            last_sub_q <= 1'b0;
            first_q    <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else if (bus.abort_h) begin
            state_q    <= ST_IDLE;
            last_sub_q <= 1'b0;
            first_q    <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    err_q <= bus.start_mul_h && bus.start_div_h;
                    if (req_mul) begin
                        state_q <= ST_MUL;
                    end else if (req_div) begin
                        state_q <= ST_DIV;
                        first_q <= 1'b1;
                    end else if (req_divz) begin
                        state_q <= ST_DONE;
                        ovf_q   <= 1'b1;
                    end
                end
                ST_MUL: begin
                    if (cnt_zero) state_q <= ST_DONE;
                end
                ST_DIV: begin
                    first_q    <= 1'b0;
                    last_sub_q <= (alu_op == ALU_SUB);
                    if (cnt_zero) state_q <= ST_FIXUP;
                end
                ST_FIXUP: begin
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ovf_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.alu_add_h    = (alu_op == ALU_ADD);
    assign bus.alu_sub_h    = (alu_op == ALU_SUB);
    assign bus.alpctl_mul_l = !((state_q == ST_MUL) || (state_q == ST_DIV));
    assign bus.step_h       = (state_q == ST_MUL) || (state_q == ST_DIV);
    // Quotient bit belongs to the step issued in the previous cycle
    assign bus.q_bit_h      = ((state_q == ST_DIV) && !first_q) || (state_q == ST_FIXUP) ? ~neg : 1'b0;
    assign bus.busy_h       = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIXUP);
    assign bus.stall_l      = !bus.busy_h;
    assign bus.done_h       = (state_q == ST_DONE);
    assign bus.ovf_h        = (state_q == ST_DONE) && ovf_q;
    assign bus.err_h        = err_q;

    always @(posedge qdclk_l) begin
        if (!reset_h) begin
            assert (!(bus.alu_add_h && bus.alu_sub_h))
                else $error("alkmdseq: alu_add_h and alu_sub_h both high");
        end
    end

endmodule

// File: tb/tb_alkmdseq.sv
// tb/tb_alkmdseq.sv - directed self-checking bench for alkmdseq
module tb_alkmdseq;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    alkmdseq_if bus ();

    alkmdseq #(
        .STEPS (32),
        .CW    (6)
    ) dut (
        .qdclk_l (clk),
        .reset_h (rst),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start_mul_h = 1'b0;
        bus.start_div_h = 1'b0;
        bus.divz_h      = 1'b0;
        bus.abort_h     = 1'b0;
        bus.mq_lsb_h    = 1'b0;
        bus.alkc_flag_h = 1'b0;
    endtask

    // MUL with mq_lsb toggling 1,0,1,... starting at step 1
    task automatic run_mul(input string tag);
        int adds = 0, stall_lo = 0, steps = 0, early_done = 0, subs = 0, alp_lo = 0;
        bus.start_mul_h = 1'b1;
        bus.mq_lsb_h    = 1'b0;
        adv();
        bus.start_mul_h = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            bus.mq_lsb_h = c[0];
            #4;
            if (c <= 32) begin
                adds       += int'(bus.alu_add_h);
                subs       += int'(bus.alu_sub_h);
                stall_lo   += int'(!bus.stall_l);
                alp_lo     += int'(!bus.alpctl_mul_l);
                steps      += int'(bus.step_h);
                early_done += int'(bus.done_h);
            end else if (c == 33) begin
                chk({tag, "_done_at_33"}, bus.done_h, 1);
                chk({tag, "_stall_rel_33"}, bus.stall_l, 1);
                chk({tag, "_busy_33"}, bus.busy_h, 0);
            end else begin
                chk({tag, "_done_clear_34"}, bus.done_h, 0);
            end
            adv();
        end
        chk({tag, "_add_steps"}, adds, 16);
        chk({tag, "_sub_steps"}, subs, 0);
        chk({tag, "_stall_low_cycles"}, stall_lo, 32);
        chk({tag, "_alpctl_low_cycles"}, alp_lo, 32);
        chk({tag, "_step_pulses"}, steps, 32);
        chk({tag, "_early_done"}, early_done, 0);
    endtask

    // DIV against a behavioural ALU: shift {A,Q} left, then A +/- D as the DUT selects
    task automatic run_div(input string tag, input int dividend, input int divisor,
                           input int exp_q, input int exp_r, input logic exp_fix);
        logic signed [33:0] a;
        logic [31:0] q, qacc;
        logic flag_n;
        int bad_op = 0, steps = 0;
        a = '0;
        q = dividend;
        qacc = '0;
        flag_n = 1'b0;
        bus.start_div_h = 1'b1;
        bus.divz_h      = 1'b0;
        adv();
        bus.start_div_h = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            bus.alkc_flag_h = flag_n;
            #4;
            if (c <= 32) begin
                steps += int'(bus.step_h && !bus.alpctl_mul_l);
                if (c == 1) chk({tag, "_first_sub"}, bus.alu_sub_h, 1);
                if (bus.alu_add_h == bus.alu_sub_h) bad_op++;
                if (c >= 2) qacc = {qacc[30:0], bus.q_bit_h};
                a = {a[32:0], q[31]};
                q = q << 1;
                if (bus.alu_sub_h) begin
                    a = a - divisor;
                    flag_n = (a < 0);
                end else begin
                    a = a + divisor;
                    flag_n = (a >= 0);
                end
            end else if (c == 33) begin
                chk({tag, "_fix_step"}, bus.step_h, 0);
                chk({tag, "_fix_alpctl"}, bus.alpctl_mul_l, 1);
                chk({tag, "_fix_add_model"}, bus.alu_add_h, (a < 0));
                chk({tag, "_fix_add_exp"}, bus.alu_add_h, exp_fix);
                chk({tag, "_fix_sub"}, bus.alu_sub_h, 0);
                qacc = {qacc[30:0], bus.q_bit_h};
                if (bus.alu_add_h) a = a + divisor;
            end else begin
                chk({tag, "_done_at_34"}, bus.done_h, 1);
                chk({tag, "_ovf_34"}, bus.ovf_h, 0);
            end
            adv();
        end
        bus.alkc_flag_h = 1'b0;
        chk({tag, "_op_exclusive"}, bad_op, 0);
        chk({tag, "_steps"}, steps, 32);
        chk({tag, "_quotient"}, qacc, exp_q);
        chk({tag, "_remainder"}, a, exp_r);
    endtask

    initial begin
        int dones;
        clear_inputs();
        rst = 1'b1;
        adv();
        adv();
        #4;
        chk("rst_alpctl", bus.alpctl_mul_l, 1);
        chk("rst_stall", bus.stall_l, 1);
        chk("rst_busy", bus.busy_h, 0);
        chk("rst_add_sub_step", {bus.alu_add_h, bus.alu_sub_h, bus.step_h, bus.q_bit_h}, 0);
        chk("rst_done_ovf_err", {bus.done_h, bus.ovf_h, bus.err_h}, 0);
        adv();
        rst = 1'b0;
        adv();

        run_mul("mul");

        run_div("div100_7", 100, 7, 14, 2, 1'b1);
        run_div("div100_11", 100, 11, 9, 1, 1'b0);

        // Divide by zero
        bus.start_div_h = 1'b1;
        bus.divz_h      = 1'b1;
        #4;
        chk("divz_alpctl_c0", bus.alpctl_mul_l, 1);
        adv();
        bus.start_div_h = 1'b0;
        bus.divz_h      = 1'b0;
        #4;
        chk("divz_done", bus.done_h, 1);
        chk("divz_ovf", bus.ovf_h, 1);
        chk("divz_alpctl_c1", bus.alpctl_mul_l, 1);
        chk("divz_busy", bus.busy_h, 0);
        adv();
        #4;
        chk("divz_after", {bus.done_h, bus.ovf_h, bus.busy_h}, 0);
        adv();

        // Abort at step 10 of MUL
        bus.start_mul_h = 1'b1;
        adv();
        bus.start_mul_h = 1'b0;
        for (int c = 1; c <= 9; c++) adv();
        #4;
        chk("abort_step10_busy", bus.busy_h, 1);
        bus.abort_h = 1'b1;
        adv();
        bus.abort_h = 1'b0;
        #4;
        chk("abort_busy", bus.busy_h, 0);
        chk("abort_stall", bus.stall_l, 1);
        chk("abort_alpctl", bus.alpctl_mul_l, 1);
        chk("abort_outs", {bus.alu_add_h, bus.alu_sub_h, bus.step_h, bus.done_h}, 0);
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            adv();
            #4;
            dones += int'(bus.done_h);
        end
        chk("abort_no_done", dones, 0);
        adv();

        // Both starts together
        bus.start_mul_h = 1'b1;
        bus.start_div_h = 1'b1;
        adv();
        bus.start_mul_h = 1'b0;
        bus.start_div_h = 1'b0;
        #4;
        chk("err_pulse", bus.err_h, 1);
        chk("err_busy", bus.busy_h, 0);
        adv();
        #4;
        chk("err_clear", bus.err_h, 0);
        chk("err_busy2", bus.busy_h, 0);
        adv();

        // Reset asserted mid-DIV
        bus.start_div_h = 1'b1;
        adv();
        bus.start_div_h = 1'b0;
        for (int c = 1; c < 5; c++) adv();
        #1;
        chk("rstdiv_busy_before", bus.busy_h, 1);
        rst = 1'b1;
        #1;
        chk("rstdiv_async_busy", bus.busy_h, 0);
        chk("rstdiv_async_alpctl", bus.alpctl_mul_l, 1);
        adv();
        #2;
        chk("rstdiv_no_done", bus.done_h, 0);
        adv();
        rst = 1'b0;
        adv();
        adv();
        run_mul("mul_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
